// File: rtl/logic_pipe_pkg.sv
// logic_pipe_pkg: shared mode encodings and default sizes for the logic pipeline
package logic_pipe_pkg;
  localparam logic [1:0] MODE_ANDOR  = 2'b00;
  localparam logic [1:0] MODE_XOR3   = 2'b01;
  localparam logic [1:0] MODE_ANDXOR = 2'b10;
  localparam logic [1:0] MODE_XORIN  = 2'b11;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one valid/ready register slice that holds its contents while stalled
module pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  // load on advance; data only changes when a new item actually arrives
  always_comb begin
    valid_d = in_ready ? in_valid : valid_q;
    data_d  = in_ready && in_valid ? in_data : data_q;
  end
  // slice register with flush on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/logic_pipe_opt.sv
// logic_pipe_opt: two-stage valid/ready bitwise function pipeline with XOR signature and result count
module logic_pipe_opt
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] count
);
  localparam int S1W = 4*WIDTH+2;
  logic             s1_valid, s2_ready, xfer;
  logic [S1W-1:0]   s1_in, s1_out;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] n1, n2, n3, n4, y_d, acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  assign s1_in = {mode, a & b, a ^ b, c, d};
  assign {s1_mode, n1, n2, n3, n4} = s1_out;
  assign xfer  = out_valid && out_ready;
  assign acc   = acc_q;
  assign count = count_q;
  pipe_reg #(.DATA_W(S1W)) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );
  // stage-2 function select from the registered partials
  always_comb
    y_d = s1_mode == MODE_ANDOR  ? n3 | n1 :
          s1_mode == MODE_XOR3   ? n2 ^ n4 :
          s1_mode == MODE_ANDXOR ? n1 ^ (n3 & n4) : n2 | n3;
  pipe_reg #(.DATA_W(WIDTH)) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (y_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (y)
  );
  // clear first, then fold in a same-cycle delivery; count saturates at all-ones
  always_comb begin
    acc_d   = (acc_clr ? '0 : acc_q) ^ (xfer ? y : '0);
    count_d = xfer && count_q != {CNT_W{1'b1}} ? count_q + 1'b1 : count_q;
  end
  // signature and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
endmodule
